bus_burst_master: RTL

//  Parametrised bus test master; successor to the fixed 4-beat test master. Arbitrates for the shared bus (req/ack),

---
 rtl/bus_burst_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bus_burst_master.sv
// Bus test master. Requests the shared bus and presents an address. It then runs
// a read or write burst of 1..MAX_BURST beats, honouring slave wait mid-burst.
// Read beats land in a small buffer that can be inspected through debug_sel/debug_out.
module bus_burst_master #(
  parameter int BUS_WIDTH      = 32,
  parameter int CTRL_WIDTH     = 8,
  parameter int MAX_BURST_LOG2 = 3,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      we_in,
  input  logic [BUS_WIDTH-1:0]      addr_in,
  input  logic [2:0]                burst_sel,
  input  logic [BUS_WIDTH-1:0]      wdata_base,
  input  logic                      ready_in,
  input  logic                      ack,
  output logic                      req,
  input  logic [BUS_WIDTH-1:0]      bus_in,
  output logic [BUS_WIDTH-1:0]      bus_out,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  output logic [CTRL_WIDTH-1:0]     ctrl_out,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  input  logic [MAX_BURST_LOG2-1:0] debug_sel,
  output logic [7:0]                debug_out
);

  localparam int MAX_BURST = 1 << MAX_BURST_LOG2;
  localparam int CW        = MAX_BURST_LOG2;
  localparam int TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_SWAIT, S_WRITE, S_READ, S_FINISH
  } state_e;

  // Everything captured at start; held stable for the whole burst.
  typedef struct packed {
    logic                 we;
    logic [2:0]           code;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] base;
  } cmd_t;

  state_e               state_q, state_d;
  cmd_t                 cmd_q, cmd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 timeout_q, timeout_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BUS_WIDTH-1:0] bus_out_q, bus_out_d;
  logic [BUS_WIDTH-1:0] rbuf_q [MAX_BURST];
  logic                 rbuf_we;

  logic                 slv_wait;
  logic [2:0]           code_clamped;
  logic [CW-1:0]        last_idx;
  logic                 to_expired;

  assign slv_wait     = ctrl_in[0];
  assign code_clamped = (burst_sel > 3'(MAX_BURST_LOG2)) ? 3'(MAX_BURST_LOG2) : burst_sel;
  // The clamp keeps the code <= MAX_BURST_LOG2, so beats-1 always fits the counter.
  assign last_idx     = CW'((32'd1 << cmd_q.code) - 32'd1);
  // to_q counts cycles already spent in the state, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign to_expired   = (to_q == TW'(TIMEOUT - 1));

  // Next-state, latched command, beat counter and timeout bookkeeping.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    timeout_d = timeout_q;
    rbuf_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && ready_in) begin
          cmd_d.we   = we_in;
          cmd_d.code = code_clamped;
          cmd_d.addr = addr_in;
          cmd_d.base = wdata_base;
          timeout_d  = 1'b0;
          to_d       = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // A grant on the final allowed cycle still wins over the abort.
        if (ack) begin
          state_d = S_ADDR;
          to_d    = '0;
        end else if (to_expired) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
          to_d      = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_ADDR: begin
        state_d = S_SWAIT;
        to_d    = '0;
      end
      S_SWAIT: begin
        if (!slv_wait) begin
          state_d = cmd_q.we ? S_WRITE : S_READ;
          to_d    = '0;
        end else if (to_expired) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
          to_d      = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_WRITE, S_READ: begin
        // Mid-burst wait only stalls; it never counts toward a timeout.
        if (!slv_wait) begin
          rbuf_we = (state_q == S_READ);
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = S_FINISH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered copies line up with the state register.
  always_comb begin
    req_d     = state_d inside {S_REQ, S_ADDR, S_SWAIT, S_WRITE, S_READ};
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    bus_out_d = '0;
    if (state_d == S_ADDR)  bus_out_d = cmd_d.addr;
    if (state_d == S_WRITE) bus_out_d = cmd_d.base + BUS_WIDTH'(cnt_d);
  end

  // State, command, counters, registered outputs and read buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      timeout_q <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bus_out_q <= '0;
      for (int i = 0; i < MAX_BURST; i++) rbuf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bus_out_q <= bus_out_d;
      if (rbuf_we) rbuf_q[cnt_q] <= bus_in;
    end
  end

  assign req       = req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign bus_out   = bus_out_q;
  assign ctrl_out  = CTRL_WIDTH'({3'b000, cmd_q.code, cmd_q.we, 1'b0});
  assign debug_out = rbuf_q[debug_sel][7:0];

  // Only the low byte of each entry and ctrl bit 0 are observed; fold the rest away.
  logic ctrl_unused;
  logic rbuf_unused;
  assign ctrl_unused = ^ctrl_in[CTRL_WIDTH-1:1];
  // Reduction over the buffer bits that debug_out never shows.
  always_comb begin
    rbuf_unused = 1'b0;
    for (int i = 0; i < MAX_BURST; i++) rbuf_unused = rbuf_unused ^ (^rbuf_q[i][BUS_WIDTH-1:8]);
  end

endmodule
